inst_prefetch_queue: RTL and testbench
======================================

# inst_prefetch_queue

Parametrised instruction prefetch queue between the fetch stage and the prime decoder of the 6502 core. It replaces the fixed 16×8 rotation queue. Additions: configurable width and depth, a variable-length pull of 1..MAX_PULL bytes per instruction (driven by the decoder's instruction length), a taken-branch flush that reloads the address, and tracking of both the fetch address and the head-instruction PC. Bytes enter one per cycle from memory and leave as whole instructions.

## Interface
Parameters:
- DATA_W, 8, byte width
- DEPTH, 16, queue entries; power of two, ≥ 4
- MAX_PULL, 3, widest pull (longest 6502 instruction)
- ADDR_W, 16, address width
- RESET_ADDR, 0, value loaded into both PCs at reset

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- queue_reset  in  1  synchronous, active-high reset
- queue_in  in  DATA_W  byte fetched from memory at fetch_pc
- queue_push  in  1  write queue_in; accepted only when queue_full is 0
- queue_full  out  1  count == DEPTH
- queue_out  out  MAX_PULL*DATA_W  head window; byte i = entry head+i mod DEPTH, byte 0 in LSBs
- queue_count  out  $clog2(DEPTH+1)  occupied entries
- queue_pull  in  1  consume queue_pull_len bytes from the head
- queue_pull_len  in  2  bytes to consume, 1..MAX_PULL
- queue_flush  in  1  taken branch/jump: discard contents, reload PCs
- queue_flush_addr  in  ADDR_W  new PC on flush
- fetch_pc  out  ADDR_W  address of the next byte to be pushed
- head_pc  out  ADDR_W  address of the byte at queue_out byte 0
- queue_err  out  1  sticky flag for an illegal pull

## Operation
- Storage: DEPTH×DATA_W register array, write pointer wp, read pointer rp, and count.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- Push accept: push_acc = queue_push & (count < DEPTH).
  - Acceptance uses the pre-edge count only. A same-cycle pull does not free space for a push.
  - On accept: mem[wp] ← queue_in, wp+1, fetch_pc+1 (mod 2^ADDR_W).
  - A push while full is dropped, and fetch_pc does not advance.
- Pull accept: pull_acc = queue_pull & (1 ≤ len ≤ MAX_PULL) & (len ≤ count).
  - On accept: rp += len, head_pc += len.
  - An illegal pull has len = 0, len > MAX_PULL, or len > count. It changes no state except setting queue_err.
- Count update: count_next = count + push_acc − (pull_acc ? len : 0). A simultaneous push and pull are both applied.
- Flush has the highest priority. It overrides push, pull and the error setting in the same cycle:
  - wp = rp = count = 0
  - fetch_pc = head_pc = queue_flush_addr
  - queue_err = 0
- queue_reset has priority over everything, including flush:
  - count = wp = rp = 0
  - fetch_pc = head_pc = RESET_ADDR
  - queue_err = 0
  - memory contents are left unchanged
- queue_out is a combinational read at rp..rp+MAX_PULL−1 with modulo wrap. Bytes at positions ≥ count are stale, and consumers must ignore them.
- queue_full is combinational from count.
- Invariant: fetch_pc − head_pc == count (mod 2^ADDR_W) at all times outside reset.

## Timing
- Reset values:
  - queue_count = 0, queue_full = 0, queue_err = 0
  - fetch_pc = head_pc = RESET_ADDR
  - queue_out is undefined (stale)
- Push latency: a byte accepted at edge N is visible in queue_out and queue_count after edge N. There is no same-cycle bypass from queue_in to queue_out.
- Pull latency: the new head window is valid after the pull edge. Back-to-back pulls every cycle are legal while count allows.
- Flush latency: takes effect at the edge where queue_flush is high. A push sampled in that cycle is discarded, and the following cycle's push is stored at the new fetch_pc.
- queue_reset asserted mid-stream discards all data at that edge. Operation resumes on the first cycle after it deasserts.
- Wrap-around is seamless: a window straddling entry DEPTH−1 → 0 returns bytes in address order.
- The bench must never see queue_count > DEPTH or underflow. Assertions cover both.

## Test plan
- Reset: hold queue_reset 2 cycles with push/pull/flush active → count=0, full=0, err=0, fetch_pc=head_pc=RESET_ADDR (0x0000).
- Fill: push 0x00..0x0F on 16 consecutive cycles, then one more push of 0xAA → full=1 after the 16th push, 17th byte dropped, fetch_pc=0x0010, queue_out=0x020100.
- Variable pull: from full, pull len 3, then 1, then 2 → head_pc 0x0003, 0x0004, 0x0006; queue_out 0x050403 then 0x060504 then 0x080706; count 13, 12, 10.
- Wrap plus simultaneous push and pull: steady state with push 1/cycle and pull len 1/cycle for 40 cycles across index 15→0 → count constant, queue_out byte 0 equals the byte pushed count cycles earlier, invariant holds.
- Flush priority: with count=5, assert flush (addr 0x8000) together with push 0x55 and pull len 2 → count=0, fetch_pc=head_pc=0x8000, 0x55 not stored; push 0xEA on the next cycle → queue_out byte 0 = 0xEA, head_pc=0x8000, fetch_pc=0x8001.
- Illegal pull: count=1, pull len 2; then pull len 0 → no state change, err=1 and stays 1; a following flush clears err to 0.

Source files
------------

// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch queue between fetch and the decoder: bytes enter one per cycle,
// whole instructions (1..MAX_PULL bytes) leave from a combinational head window.
module inst_prefetch_queue #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 16,
  parameter int MAX_PULL = 3,
  parameter int ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
  input  logic                         clk,
  input  logic                         queue_reset,
  input  logic [DATA_W-1:0]            queue_in,
  input  logic                         queue_push,
  output logic                         queue_full,
  output logic [MAX_PULL*DATA_W-1:0]   queue_out,
  output logic [$clog2(DEPTH+1)-1:0]   queue_count,
  input  logic                         queue_pull,
  input  logic [1:0]                   queue_pull_len,
  input  logic                         queue_flush,
  input  logic [ADDR_W-1:0]            queue_flush_addr,
  output logic [ADDR_W-1:0]            fetch_pc,
  output logic [ADDR_W-1:0]            head_pc,
  output logic                         queue_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [1:0]       MAX_LEN  = 2'(MAX_PULL);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wp;
  logic [PTR_W-1:0]  r_rp;
  logic [CNT_W-1:0]  r_count;
  logic [ADDR_W-1:0] r_fetch_pc;
  logic [ADDR_W-1:0] r_head_pc;
  logic              r_err;

  logic              w_push_acc;
  logic              w_len_ok;
  logic              w_pull_acc;
  logic [CNT_W-1:0]  w_pull_cnt;

  // Space is judged on the pre-edge count; a same-cycle pull never makes room for a push.
  assign w_push_acc = queue_push & (r_count < FULL_CNT);
  assign w_len_ok   = (queue_pull_len != 2'd0) & (queue_pull_len <= MAX_LEN);
  assign w_pull_acc = queue_pull & w_len_ok & (CNT_W'(queue_pull_len) <= r_count);
  assign w_pull_cnt = w_pull_acc ? CNT_W'(queue_pull_len) : '0;

  always_ff @(posedge clk) begin
    if (queue_reset) begin
      r_wp       <= '0;
      r_rp       <= '0;
      r_count    <= '0;
      r_fetch_pc <= RESET_ADDR;
      r_head_pc  <= RESET_ADDR;
      r_err      <= 1'b0;
    end else if (queue_flush) begin
      r_wp       <= '0;
      r_rp       <= '0;
      r_count    <= '0;
      r_fetch_pc <= queue_flush_addr;
      r_head_pc  <= queue_flush_addr;
      r_err      <= 1'b0;
    end else begin
      if (w_push_acc) begin
        r_wp       <= r_wp + 1'b1;
        r_fetch_pc <= r_fetch_pc + 1'b1;
      end
      if (w_pull_acc) begin
        r_rp      <= r_rp + PTR_W'(queue_pull_len);
        r_head_pc <= r_head_pc + ADDR_W'(queue_pull_len);
      end else if (queue_pull) begin
        r_err <= 1'b1;
      end
      r_count <= r_count + CNT_W'(w_push_acc) - w_pull_cnt;
    end
  end

  // Storage keeps its contents through reset; only the pointers are cleared.
  always_ff @(posedge clk) begin
    if (w_push_acc & ~queue_flush & ~queue_reset) begin
      r_mem[r_wp] <= queue_in;
    end
  end

  for (genvar gi = 0; gi < MAX_PULL; gi++) begin : g_win
    assign queue_out[gi*DATA_W +: DATA_W] = r_mem[r_rp + PTR_W'(gi)];
  end

  assign queue_full  = (r_count == FULL_CNT);
  assign queue_count = r_count;
  assign fetch_pc    = r_fetch_pc;
  assign head_pc     = r_head_pc;
  assign queue_err   = r_err;

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Bench for inst_prefetch_queue: directed scenarios plus randomized traffic,
// checked against a byte-queue reference model.
module tb_inst_prefetch_queue;

  logic        clk = 1'b0;
  logic        queue_reset = 1'b0;
  logic [7:0]  queue_in = '0;
  logic        queue_push = 1'b0;
  logic        queue_full;
  logic [23:0] queue_out;
  logic [4:0]  queue_count;
  logic        queue_pull = 1'b0;
  logic [1:0]  queue_pull_len = '0;
  logic        queue_flush = 1'b0;
  logic [15:0] queue_flush_addr = '0;
  logic [15:0] fetch_pc;
  logic [15:0] head_pc;
  logic        queue_err;

  int checks = 0;
  int errors = 0;

  // Reference model: the queue as a list of bytes in address order.
  logic [7:0]  mq[$];
  logic [15:0] m_fpc;
  logic [15:0] m_hpc;
  logic        m_err;

  always #5 clk = ~clk;

  inst_prefetch_queue dut (
    .clk(clk), .queue_reset(queue_reset), .queue_in(queue_in), .queue_push(queue_push),
    .queue_full(queue_full), .queue_out(queue_out), .queue_count(queue_count),
    .queue_pull(queue_pull), .queue_pull_len(queue_pull_len), .queue_flush(queue_flush),
    .queue_flush_addr(queue_flush_addr), .fetch_pc(fetch_pc), .head_pc(head_pc),
    .queue_err(queue_err)
  );

  task automatic step(input logic rst, input logic push, input logic [7:0] din,
                      input logic pull, input logic [1:0] len,
                      input logic flush, input logic [15:0] faddr);
    bit push_ok, pull_ok;
    @(negedge clk);
    queue_reset = rst; queue_push = push; queue_in = din;
    queue_pull = pull; queue_pull_len = len;
    queue_flush = flush; queue_flush_addr = faddr;
    @(posedge clk);
    if (rst) begin
      mq.delete(); m_fpc = 16'h0000; m_hpc = 16'h0000; m_err = 1'b0;
    end else if (flush) begin
      mq.delete(); m_fpc = faddr; m_hpc = faddr; m_err = 1'b0;
    end else begin
      push_ok = push && (mq.size() < 16);
      pull_ok = pull && (len >= 1) && (len <= 3) && (int'(len) <= mq.size());
      if (pull_ok) begin
        for (int k = 0; k < int'(len); k++) void'(mq.pop_front());
        m_hpc = m_hpc + 16'(len);
      end else if (pull) begin
        m_err = 1'b1;
      end
      if (push_ok) begin
        mq.push_back(din);
        m_fpc = m_fpc + 16'd1;
      end
    end
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 16'h0000);
  endtask

  task automatic test_reset();
    step(1'b1, 1'b1, 8'h77, 1'b1, 2'd1, 1'b1, 16'h1234);
    step(1'b1, 1'b1, 8'h78, 1'b1, 2'd2, 1'b1, 16'h4321);
    checks++; if (queue_count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", queue_count); end
    checks++; if (queue_full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", queue_full); end
    checks++; if (queue_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", queue_err); end
    checks++; if (fetch_pc !== 16'h0000) begin errors++; $display("FAIL reset_fetch_pc got %h exp 0000", fetch_pc); end
    checks++; if (head_pc !== 16'h0000) begin errors++; $display("FAIL reset_head_pc got %h exp 0000", head_pc); end
    idle();
    checks++; if (queue_count !== 5'd0) begin errors++; $display("FAIL reset_idle_count got %0d exp 0", queue_count); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 8'(i), 1'b0, 2'd0, 1'b0, 16'h0000);
      checks++;
      if (queue_full !== (i == 15)) begin errors++; $display("FAIL fill_full[%0d] got %b exp %b", i, queue_full, i == 15); end
    end
    step(1'b0, 1'b1, 8'hAA, 1'b0, 2'd0, 1'b0, 16'h0000);
    checks++; if (queue_count !== 5'd16) begin errors++; $display("FAIL fill_count got %0d exp 16", queue_count); end
    checks++; if (fetch_pc !== 16'h0010) begin errors++; $display("FAIL fill_fetch_pc got %h exp 0010", fetch_pc); end
    checks++; if (queue_out !== 24'h020100) begin errors++; $display("FAIL fill_out got %h exp 020100", queue_out); end
    checks++; if (queue_full !== 1'b1) begin errors++; $display("FAIL fill_full_drop got %b exp 1", queue_full); end
  endtask

  task automatic test_var_pull();
    logic [1:0]  lens [3] = '{2'd3, 2'd1, 2'd2};
    logic [15:0] hpcs [3] = '{16'h0003, 16'h0004, 16'h0006};
    logic [23:0] outs [3] = '{24'h050403, 24'h060504, 24'h080706};
    logic [4:0]  cnts [3] = '{5'd13, 5'd12, 5'd10};
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 8'h00, 1'b1, lens[i], 1'b0, 16'h0000);
      checks++; if (head_pc !== hpcs[i]) begin errors++; $display("FAIL pull_head_pc[%0d] got %h exp %h", i, head_pc, hpcs[i]); end
      checks++; if (queue_out !== outs[i]) begin errors++; $display("FAIL pull_out[%0d] got %h exp %h", i, queue_out, outs[i]); end
      checks++; if (queue_count !== cnts[i]) begin errors++; $display("FAIL pull_count[%0d] got %0d exp %0d", i, queue_count, cnts[i]); end
    end
  endtask

  task automatic test_wrap();
    logic [4:0] start_cnt;
    start_cnt = queue_count;
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 1'b1, 8'($urandom), 1'b1, 2'd1, 1'b0, 16'h0000);
      checks++; if (queue_count !== start_cnt) begin errors++; $display("FAIL wrap_count[%0d] got %0d exp %0d", i, queue_count, start_cnt); end
      checks++; if (queue_out[7:0] !== mq[0]) begin errors++; $display("FAIL wrap_byte0[%0d] got %h exp %h", i, queue_out[7:0], mq[0]); end
      checks++; if (fetch_pc - head_pc !== 16'(start_cnt)) begin errors++; $display("FAIL wrap_invariant[%0d] got %h exp %h", i, fetch_pc - head_pc, start_cnt); end
    end
  endtask

  task automatic test_flush();
    step(1'b0, 1'b0, 8'h00, 1'b0, 2'd0, 1'b1, 16'h1000);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'(8'h30 + i), 1'b0, 2'd0, 1'b0, 16'h0000);
    checks++; if (queue_count !== 5'd5) begin errors++; $display("FAIL flush_pre_count got %0d exp 5", queue_count); end
    step(1'b0, 1'b1, 8'h55, 1'b1, 2'd2, 1'b1, 16'h8000);
    checks++; if (queue_count !== 5'd0) begin errors++; $display("FAIL flush_count got %0d exp 0", queue_count); end
    checks++; if (fetch_pc !== 16'h8000) begin errors++; $display("FAIL flush_fetch_pc got %h exp 8000", fetch_pc); end
    checks++; if (head_pc !== 16'h8000) begin errors++; $display("FAIL flush_head_pc got %h exp 8000", head_pc); end
    step(1'b0, 1'b1, 8'hEA, 1'b0, 2'd0, 1'b0, 16'h0000);
    checks++; if (queue_out[7:0] !== 8'hEA) begin errors++; $display("FAIL flush_byte0 got %h exp EA", queue_out[7:0]); end
    checks++; if (head_pc !== 16'h8000) begin errors++; $display("FAIL flush_push_head_pc got %h exp 8000", head_pc); end
    checks++; if (fetch_pc !== 16'h8001) begin errors++; $display("FAIL flush_push_fetch_pc got %h exp 8001", fetch_pc); end
    checks++; if (queue_count !== 5'd1) begin errors++; $display("FAIL flush_push_count got %0d exp 1", queue_count); end
  endtask

  task automatic test_illegal_pull();
    step(1'b0, 1'b0, 8'h00, 1'b1, 2'd2, 1'b0, 16'h0000);
    checks++; if (queue_err !== 1'b1) begin errors++; $display("FAIL illegal_err_len2 got %b exp 1", queue_err); end
    checks++; if (queue_count !== 5'd1) begin errors++; $display("FAIL illegal_count got %0d exp 1", queue_count); end
    checks++; if (head_pc !== 16'h8000) begin errors++; $display("FAIL illegal_head_pc got %h exp 8000", head_pc); end
    step(1'b0, 1'b0, 8'h00, 1'b1, 2'd0, 1'b0, 16'h0000);
    checks++; if (queue_err !== 1'b1) begin errors++; $display("FAIL illegal_err_len0 got %b exp 1", queue_err); end
    checks++; if (queue_out[7:0] !== 8'hEA) begin errors++; $display("FAIL illegal_byte0 got %h exp EA", queue_out[7:0]); end
    idle();
    checks++; if (queue_err !== 1'b1) begin errors++; $display("FAIL illegal_err_sticky got %b exp 1", queue_err); end
    step(1'b0, 1'b0, 8'h00, 1'b0, 2'd0, 1'b1, 16'h0200);
    checks++; if (queue_err !== 1'b0) begin errors++; $display("FAIL illegal_err_clear got %b exp 0", queue_err); end
  endtask

  task automatic test_random();
    logic       push, pull, flush, rst;
    logic [1:0] len;
    for (int i = 0; i < 600; i++) begin
      push  = ($urandom_range(0, 3) != 0);
      pull  = ($urandom_range(0, 1) != 0);
      len   = 2'($urandom_range(0, 3));
      flush = ($urandom_range(0, 39) == 0);
      rst   = ($urandom_range(0, 149) == 0);
      step(rst, push, 8'($urandom), pull, len, flush, 16'($urandom));
      checks++; if (queue_count !== 5'(mq.size())) begin errors++; $display("FAIL rnd_count[%0d] got %0d exp %0d", i, queue_count, mq.size()); end
      checks++; if (queue_full !== (mq.size() == 16)) begin errors++; $display("FAIL rnd_full[%0d] got %b", i, queue_full); end
      checks++; if (queue_err !== m_err) begin errors++; $display("FAIL rnd_err[%0d] got %b exp %b", i, queue_err, m_err); end
      checks++; if (fetch_pc !== m_fpc) begin errors++; $display("FAIL rnd_fetch_pc[%0d] got %h exp %h", i, fetch_pc, m_fpc); end
      checks++; if (head_pc !== m_hpc) begin errors++; $display("FAIL rnd_head_pc[%0d] got %h exp %h", i, head_pc, m_hpc); end
      for (int b = 0; b < 3; b++) begin
        if (b < mq.size()) begin
          checks++;
          if (queue_out[b*8 +: 8] !== mq[b]) begin errors++; $display("FAIL rnd_byte%0d[%0d] got %h exp %h", b, i, queue_out[b*8 +: 8], mq[b]); end
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 8'(8'hC0 + i), 1'b0, 2'd0, 1'b0, 16'h0000);
    step(1'b1, 1'b1, 8'hFF, 1'b1, 2'd1, 1'b0, 16'h0000);
    checks++; if (queue_count !== 5'd0) begin errors++; $display("FAIL midrst_count got %0d exp 0", queue_count); end
    checks++; if (fetch_pc !== 16'h0000 || head_pc !== 16'h0000) begin errors++; $display("FAIL midrst_pcs got %h/%h exp 0000/0000", fetch_pc, head_pc); end
    step(1'b0, 1'b1, 8'h3C, 1'b0, 2'd0, 1'b0, 16'h0000);
    checks++; if (queue_out[7:0] !== 8'h3C) begin errors++; $display("FAIL midrst_resume got %h exp 3C", queue_out[7:0]); end
    checks++; if (fetch_pc !== 16'h0001) begin errors++; $display("FAIL midrst_fetch_pc got %h exp 0001", fetch_pc); end
  endtask

  // Occupancy must stay within the array at every edge outside reset.
  always @(negedge clk) begin
    if (!queue_reset && queue_count !== 5'bx) begin
      checks++;
      if (queue_count > 5'd16) begin errors++; $display("FAIL count_bound got %0d exp <=16", queue_count); end
    end
  end

  initial begin
    mq.delete(); m_fpc = '0; m_hpc = '0; m_err = 1'b0;
    test_reset();
    test_fill();
    test_var_pull();
    test_wrap();
    test_flush();
    test_illegal_pull();
    test_random();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
